// File: rtl/tri_wire_pkg.sv
// Shared types for the wireframe triangle edge generator: FSM states, screen
// coordinates, vertex record and the widths used by the Bresenham arithmetic.
package tri_wire_pkg;

   localparam int DELTA_W = 11;
   localparam int ERR_W   = 12;

   typedef logic [8:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } vertex_t;

   typedef enum logic [1:0] {
      COLLECT,
      SETUP,
      DRAW,
      NEXT
   } state_e;

   function automatic coord_t abs_diff(input coord_t a, input coord_t b);
      return (a < b) ? (b - a) : (a - b);
   endfunction

endpackage

// File: rtl/tri_wire_draw_line_stepper.sv
// Single-edge Bresenham core: start loads endpoints a->b, each step_in advances
// the current point by one pixel, done_out flags the current point equals b.
module line_stepper
   import tri_wire_pkg::*;
(
   input  logic    clk_in,
   input  logic    rst_n_in,
   input  logic    start_in,
   input  vertex_t a_in,
   input  vertex_t b_in,
   input  logic    step_in,
   output coord_t  cx_out,
   output coord_t  cy_out,
   output logic    done_out
);

   coord_t                    cx_q, cx_d, cy_q, cy_d;
   vertex_t                   b_q, b_d;
   logic signed [DELTA_W-1:0] dx_q, dx_d, dy_q, dy_d;
   logic                      sx_q, sx_d, sy_q, sy_d;
   logic signed [ERR_W-1:0]   err_q, err_d;
   logic signed [ERR_W:0]     e2;

   assign e2 = {err_q, 1'b0};

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
      cx_d  = cx_q;
      cy_d  = cy_q;
      b_d   = b_q;
      dx_d  = dx_q;
      dy_d  = dy_q;
      sx_d  = sx_q;
      sy_d  = sy_q;
      err_d = err_q;
      if (start_in) begin
         cx_d  = a_in.x;
         cy_d  = a_in.y;
         b_d   = b_in;
         dx_d  = $signed({2'b00, abs_diff(a_in.x, b_in.x)});
         dy_d  = -$signed({2'b00, abs_diff(a_in.y, b_in.y)});
         sx_d  = a_in.x < b_in.x;
         sy_d  = a_in.y < b_in.y;
         err_d = ERR_W'(dx_d) + ERR_W'(dy_d);
      end else if (step_in) begin
         // NOTE: blocking '=' here lets both axis updates accumulate into err_d
         // within one cycle, while e2 keeps the pre-step error for both tests.
         if (e2 >= (ERR_W+1)'(dy_q)) begin
            err_d = err_d + ERR_W'(dy_q);
            cx_d  = sx_q ? cx_q + 9'd1 : cx_q - 9'd1;
         end
         if (e2 <= (ERR_W+1)'(dx_q)) begin
            err_d = err_d + ERR_W'(dx_q);
            cy_d  = sy_q ? cy_q + 9'd1 : cy_q - 9'd1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         cx_q  <= '0;
         cy_q  <= '0;
         b_q   <= '0;
         dx_q  <= '0;
         dy_q  <= '0;
         sx_q  <= 1'b0;
         sy_q  <= 1'b0;
         err_q <= '0;
      end else begin
         cx_q  <= cx_d;
         cy_q  <= cy_d;
         b_q   <= b_d;
         dx_q  <= dx_d;
         dy_q  <= dy_d;
         sx_q  <= sx_d;
         sy_q  <= sy_d;
         err_q <= err_d;
      end
   end

   assign cx_out   = cx_q;
   assign cy_out   = cy_q;
   assign done_out = (cx_q == b_q.x) && (cy_q == b_q.y);

endmodule

// File: rtl/tri_wire_draw.sv
// Wireframe edge generator: gathers three projected vertices, walks the edges
// v0->v1, v1->v2, v2->v0 and streams on-screen pixels; forwards end-of-object.
module tri_wire_draw
   import tri_wire_pkg::*;
#(
   parameter int unsigned WIDTH  = 360,
   parameter int unsigned HEIGHT = 360
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic [2:0][8:0] coor_in,
   input  logic            valid_in,
   input  logic            obj_done_in,
   output logic            ready_out,
   output logic [8:0]      pix_x_out,
   output logic [8:0]      pix_y_out,
   output logic            pix_valid_out,
   input  logic            pix_ready_in,
   output logic            obj_done_out
);

   state_e     state_q, state_d;
   logic [1:0] vcnt_q, vcnt_d;
   logic [1:0] edge_idx_q, edge_idx_d;
   logic       ready_q, ready_d;
   logic       obj_done_q, obj_done_d;
   vertex_t    vert_q [3];
   vertex_t    vert_d [3];
   vertex_t    v_in, a_sel, b_sel;
   coord_t     cx, cy;
   logic       at_end, on_screen, step;
   logic       unused_z;

   assign unused_z  = ^coor_in[0];
   assign v_in      = '{x: coor_in[2], y: coor_in[1]};
   assign on_screen = ({23'd0, cx} < WIDTH) && ({23'd0, cy} < HEIGHT);
   // Off-screen points still take one DRAW cycle but never raise pix_valid_out.
   assign step      = (state_q == DRAW) && (pix_ready_in || !on_screen);

   always_comb begin
      a_sel = vert_q[2];
      b_sel = vert_q[0];
      case (edge_idx_q)
         2'd0: begin a_sel = vert_q[0]; b_sel = vert_q[1]; end
         2'd1: begin a_sel = vert_q[1]; b_sel = vert_q[2]; end
         default: ;
      endcase
   end

   line_stepper u_stepper (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .start_in (state_q == SETUP),
      .a_in     (a_sel),
      .b_in     (b_sel),
      .step_in  (step && !at_end),
      .cx_out   (cx),
      .cy_out   (cy),
      .done_out (at_end)
   );

   always_comb begin
      state_d    = state_q;
      vcnt_d     = vcnt_q;
      edge_idx_d = edge_idx_q;
      vert_d     = vert_q;
      unique case (state_q)
         COLLECT: begin
            if (obj_done_in && (vcnt_q != 2'd0)) begin
               vcnt_d = '0;
            end else if (valid_in && ready_q) begin
               case (vcnt_q)
                  2'd0:    vert_d[0] = v_in;
                  2'd1:    vert_d[1] = v_in;
                  default: vert_d[2] = v_in;
               endcase
               if (vcnt_q == 2'd2) begin
                  vcnt_d     = '0;
                  edge_idx_d = '0;
                  state_d    = SETUP;
               end else begin
                  vcnt_d = vcnt_q + 2'd1;
               end
            end
         end
         SETUP: state_d = DRAW;
         DRAW: begin
            if (step && at_end) state_d = NEXT;
         end
         NEXT: begin
            if (edge_idx_q != 2'd2) begin
               edge_idx_d = edge_idx_q + 2'd1;
               state_d    = SETUP;
            end else begin
               edge_idx_d = '0;
               state_d    = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
      ready_d    = (state_d == COLLECT);
      obj_done_d = (state_q == COLLECT) && (vcnt_q == 2'd0) && obj_done_in;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q    <= COLLECT;
         vcnt_q     <= '0;
         edge_idx_q <= '0;
         ready_q    <= 1'b0;
         obj_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         vcnt_q     <= vcnt_d;
         edge_idx_q <= edge_idx_d;
         ready_q    <= ready_d;
         obj_done_q <= obj_done_d;
      end
   end

   // NOTE: vertex storage has no reset; clearing vcnt on reset already discards
   // it, and every slot is rewritten before a triangle reads it.
   always_ff @(posedge clk_in) begin
      vert_q <= vert_d;
   end

   assign ready_out     = ready_q;
   assign obj_done_out  = obj_done_q;
   assign pix_x_out     = cx;
   assign pix_y_out     = cy;
   assign pix_valid_out = (state_q == DRAW) && on_screen;

endmodule

// File: tb/tb_tri_wire_draw.sv
// Directed plus randomized bench for tri_wire_draw against an integer
// Bresenham reference model with a scoreboard queue of expected pixels.
module tb_tri_wire_draw;

   localparam int WIDTH  = 360;
   localparam int HEIGHT = 360;

   logic            clk_in = 1'b0;
   logic            rst_n_in;
   logic [2:0][8:0] coor_in;
   logic            valid_in;
   logic            obj_done_in;
   logic            ready_out;
   logic [8:0]      pix_x_out;
   logic [8:0]      pix_y_out;
   logic            pix_valid_out;
   logic            pix_ready_in;
   logic            obj_done_out;

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   tri_wire_draw #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .coor_in       (coor_in),
      .valid_in      (valid_in),
      .obj_done_in   (obj_done_in),
      .ready_out     (ready_out),
      .pix_x_out     (pix_x_out),
      .pix_y_out     (pix_y_out),
      .pix_valid_out (pix_valid_out),
      .pix_ready_in  (pix_ready_in),
      .obj_done_out  (obj_done_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer Bresenham per edge, off-screen points dropped.
   // Returns the expected ready_out-low cycle count for an unstalled run.
   function automatic int model_tri(input int x0, input int y0, input int x1,
                                    input int y1, input int x2, input int y2);
      int vx[3];
      int vy[3];
      int cyc;
      cyc = 0;
      vx[0] = x0; vx[1] = x1; vx[2] = x2;
      vy[0] = y0; vy[1] = y1; vy[2] = y2;
      for (int e = 0; e < 3; e++) begin
         int ax, ay, bx, by, dx, dy, sx, sy, err, e2, x, y;
         ax = vx[e];  ay = vy[e];
         bx = vx[(e + 1) % 3];  by = vy[(e + 1) % 3];
         dx = (bx > ax) ? bx - ax : ax - bx;
         dy = -((by > ay) ? by - ay : ay - by);
         sx = (ax < bx) ? 1 : -1;
         sy = (ay < by) ? 1 : -1;
         err = dx + dy;
         x = ax;  y = ay;
         forever begin
            if (x < WIDTH && y < HEIGHT) exp_q.push_back(x * 512 + y);
            if (x == bx && y == by) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
         end
         cyc += ((dx > -dy) ? dx : -dy) + 1 + 2;
      end
      return cyc;
   endfunction

   // Called at a negedge; returns at the negedge following acceptance.
   task automatic send_vtx(input int x, input int y);
      int guard;
      guard = 0;
      coor_in  = {9'(x), 9'(y), 9'd0};
      valid_in = 1'b1;
      while (!ready_out && guard < 50) begin
         @(negedge clk_in);
         guard++;
      end
      check("vtx_ready", 32'(ready_out), 32'd1);
      @(posedge clk_in);
      @(negedge clk_in);
      valid_in = 1'b0;
   endtask

   // stall: 0 = always ready, 1 = toggle each cycle, 2 = random.
   task automatic run_tri(input string tag, input int x0, input int y0, input int x1,
                          input int y1, input int x2, input int y2, input int stall,
                          input bit junk, output int got, output int cyc);
      int         exp_cyc, n_exp, first_on;
      bit         prev_stall;
      logic [8:0] px, py;
      exp_q.delete();
      exp_cyc  = model_tri(x0, y0, x1, y1, x2, y2);
      n_exp    = exp_q.size();
      first_on = (x0 < WIDTH && y0 < HEIGHT) ? 1 : 0;
      send_vtx(x0, y0);
      send_vtx(x1, y1);
      send_vtx(x2, y2);
      if (junk) begin
         valid_in = 1'b1;
         coor_in  = {9'd7, 9'd7, 9'd0};
      end
      got = 0;
      cyc = 0;
      prev_stall = 1'b0;
      px = '0;
      py = '0;
      while (!ready_out && cyc < 4000) begin
         cyc++;
         if (prev_stall)
            check({tag, "_stall_hold"}, {13'd0, pix_valid_out, pix_x_out, pix_y_out},
                  {13'd0, 1'b1, px, py});
         if (cyc == 1) check({tag, "_setup_novalid"}, 32'(pix_valid_out), 32'd0);
         if (cyc == 2 && stall == 0 && first_on == 1)
            check({tag, "_first_pix_lat"}, 32'(pix_valid_out), 32'd1);
         case (stall)
            0:       pix_ready_in = 1'b1;
            1:       pix_ready_in = cyc[0];
            default: pix_ready_in = 1'($urandom);
         endcase
         if (pix_valid_out && pix_ready_in) begin
            if (exp_q.size() == 0) check({tag, "_extra_pix"}, {14'd0, pix_x_out, pix_y_out}, 32'hffff_ffff);
            else check({tag, "_pix"}, {14'd0, pix_x_out, pix_y_out}, 32'(exp_q.pop_front()));
            got++;
         end
         prev_stall = pix_valid_out && !pix_ready_in;
         px = pix_x_out;
         py = pix_y_out;
         @(negedge clk_in);
      end
      valid_in     = 1'b0;
      pix_ready_in = 1'b1;
      check({tag, "_ready_back"}, 32'(ready_out), 32'd1);
      check({tag, "_pix_count"}, 32'(got), 32'(n_exp));
      if (stall == 0) check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
   endtask

   initial begin
      int got, cyc;
      rst_n_in     = 1'b0;
      coor_in      = '0;
      valid_in     = 1'b0;
      obj_done_in  = 1'b0;
      pix_ready_in = 1'b1;
      repeat (2) @(negedge clk_in);
      check("rst_ready",    32'(ready_out),     32'd0);
      check("rst_valid",    32'(pix_valid_out), 32'd0);
      check("rst_x",        32'(pix_x_out),     32'd0);
      check("rst_y",        32'(pix_y_out),     32'd0);
      check("rst_obj_done", 32'(obj_done_out),  32'd0);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      check("rst_ready_rise", 32'(ready_out), 32'd1);

      run_tri("tri1", 10, 10, 13, 10, 10, 12, 0, 1'b0, got, cyc);
      check("tri1_n11", 32'(got), 32'd11);
      check("tri1_c17", 32'(cyc), 32'd17);

      run_tri("degen", 50, 60, 50, 60, 50, 60, 0, 1'b1, got, cyc);
      check("degen_n3", 32'(got), 32'd3);
      check("degen_c9", 32'(cyc), 32'd9);

      run_tri("clip", 350, 5, 370, 5, 360, 9, 0, 1'b0, got, cyc);
      run_tri("toggle", 100, 100, 119, 100, 100, 101, 1, 1'b0, got, cyc);

      // Reset in the middle of a long edge.
      send_vtx(10, 10);
      send_vtx(200, 10);
      send_vtx(10, 50);
      repeat (5) @(negedge clk_in);
      check("mid_draw_active", 32'(pix_valid_out), 32'd1);
      rst_n_in = 1'b0;
      @(negedge clk_in);
      check("mid_rst_valid", 32'(pix_valid_out), 32'd0);
      check("mid_rst_ready", 32'(ready_out),     32'd0);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      check("mid_rst_ready_rise", 32'(ready_out), 32'd1);
      check("mid_rst_idle",       32'(pix_valid_out), 32'd0);
      run_tri("after_rst", 10, 10, 13, 10, 10, 12, 0, 1'b0, got, cyc);

      // Partial triangle discarded by end-of-object.
      send_vtx(1, 1);
      send_vtx(2, 2);
      obj_done_in = 1'b1;
      @(negedge clk_in);
      check("od_partial_out", 32'(obj_done_out),  32'd0);
      check("od_no_pix",      32'(pix_valid_out), 32'd0);
      @(negedge clk_in);
      check("od_out_high",  32'(obj_done_out),  32'd1);
      check("od_ready",     32'(ready_out),     32'd1);
      check("od_no_pix2",   32'(pix_valid_out), 32'd0);
      obj_done_in = 1'b0;
      @(negedge clk_in);
      check("od_out_low", 32'(obj_done_out), 32'd0);
      run_tri("after_od", 10, 10, 13, 10, 10, 12, 0, 1'b0, got, cyc);

      for (int i = 0; i < 6; i++) begin
         run_tri((i == 0) ? "rand_nostall" : "rand",
                 int'($urandom_range(420, 0)), int'($urandom_range(420, 0)),
                 int'($urandom_range(420, 0)), int'($urandom_range(420, 0)),
                 int'($urandom_range(420, 0)), int'($urandom_range(420, 0)),
                 (i == 0) ? 0 : 2, 1'(i % 2), got, cyc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tri_wire_draw.md
# tri_wire_draw

Wireframe edge generator that sits directly downstream of the triangle projection stage. It collects three projected 9-bit screen-space vertices and walks the three triangle edges (v0→v1, v1→v2, v2→v0) with integer Bresenham stepping. It emits one on-screen pixel coordinate per cycle to the framebuffer writer over a valid/ready stream. It also forwards the end-of-object indication once all accepted geometry has been drawn.

## Interface
- WIDTH, 360, horizontal screen size; pixels with x ≥ WIDTH are suppressed.
- HEIGHT, 360, vertical screen size; pixels with y ≥ HEIGHT are suppressed.
- clk_in  input  1  system clock; all logic is on the rising edge.
- rst_n_in  input  1  synchronous, active-low reset.
- coor_in  input  [8:0] x3  vertex from the projection stage: [2]=x, [1]=y, [0]=z (z is ignored).
- valid_in  input  1  vertex valid; accepted on a cycle where valid_in && ready_out.
- obj_done_in  input  1  upstream end-of-object level.
- ready_out  output  1  vertex slot available; drives the projection stage's ready_in.
- pix_x_out  output  9  pixel x.
- pix_y_out  output  9  pixel y.
- pix_valid_out  output  1  pixel valid.
- pix_ready_in  input  1  downstream pixel accept.
- obj_done_out  output  1  end-of-object, qualified by drain.

## Operation
- States:
  - COLLECT: ready_out=1. Each accepted vertex is stored in slot vcnt, then vcnt increments. Accepting the third vertex (vcnt=2) clears vcnt, drops ready_out and moves to SETUP with edge=0.
  - SETUP (1 cycle): loads the edge endpoints (a,b) = (v0,v1), (v1,v2) or (v2,v0) by edge index.
    - cx=ax, cy=ay.
    - dx=|bx−ax|, dy=−|by−ay|; both signed 11-bit.
    - sx=+1 if ax<bx, else −1; sy likewise on y.
    - err=dx+dy, signed 12-bit.
    - Then → DRAW.
  - DRAW: presents (cx,cy) as the current pixel. The step fires when the pixel is accepted (pix_valid_out && pix_ready_in) or suppressed (off-screen).
    - On a step, if cx==bx && cy==by → NEXT.
    - Otherwise, with e2=2·err: if e2 ≥ dy then err+=dy and cx+=sx; if e2 ≤ dx then err+=dx and cy+=sy. Both updates apply in the same cycle using the old err.
  - NEXT (1 cycle): if edge<2, edge++ and → SETUP; else → COLLECT.
- Shared vertices are emitted once per edge that touches them, so each vertex appears twice per triangle. This is intended.
- Degenerate edge (a==b): emits exactly one pixel.
- Off-screen pixels (cx ≥ WIDTH or cy ≥ HEIGHT) are suppressed: pix_valid_out stays 0 for that step, and stepping costs 1 cycle.
- All coordinates are unsigned 9-bit (0..511). The step arithmetic is signed and cannot wrap within an edge.
- obj_done handling:
  - obj_done_out=1 on the cycle after obj_done_in=1 is sampled while the block is in COLLECT with vcnt=0.
  - It is held while those conditions hold; in any other state it is 0.
  - If obj_done_in=1 is sampled in COLLECT with vcnt=1 or 2, the partial triangle is discarded (vcnt←0) and no pixels are emitted.
- valid_in while ready_out=0 is ignored; no vertex is stored.

## Timing
- Reset (rst_n_in=0 at a clock edge), all registered outputs:
  - state=COLLECT, vcnt=0, edge=0.
  - ready_out=0; it rises on the first cycle after reset is released.
  - pix_valid_out=0, pix_x_out=0, pix_y_out=0, obj_done_out=0.
- Reset mid-draw aborts immediately. Stored vertices are discarded and no further pixels are emitted.
- Latency: third vertex accepted at cycle N → ready_out=0 at N+1 → first pixel valid at N+2.
- Throughput: 1 pixel per cycle under continuous pix_ready_in.
- Per-edge overhead: 2 cycles (SETUP + NEXT).
- Triangle cost: Σ(max(dx,|dy|)+1) + 6 cycles.
- Stall: while pix_valid_out && !pix_ready_in, pix_x_out/pix_y_out/pix_valid_out hold stable and no internal state changes.
- pix_valid_out never drops without an accept.
- ready_out returns high the cycle after NEXT with edge=2.

## Structure
- Package tri_wire_pkg holds:
  - the state enum (COLLECT, SETUP, DRAW, NEXT);
  - typedef coord_t = logic [8:0];
  - the vertex struct {x, y};
  - localparams for the delta width (11) and error width (12).
- Sub-module line_stepper: single-edge Bresenham core with start/done, current point output and step enable. The parent owns vertex storage, edge sequencing, handshakes and obj_done.

## Test plan
- Triangle (10,10), (13,10), (10,12) with pix_ready_in=1 → pixels:
  - (10,10)…(13,10)
  - (13,10), (11,11) or (12,11) per Bresenham, (10,12)
  - (10,12), (10,11), (10,10)
  - 11 pixels in 17 cycles; ready_out high again at the end.
- Degenerate triangle, all vertices (50,60) → 3 pixels at (50,60); ready_out=0 for exactly 9 cycles.
- Edge (350,5)→(370,5) with WIDTH=360 → only x=350..359 emitted on that edge; total cycles unchanged.
- pix_ready_in toggling 1/0 every cycle during a 20-pixel edge → outputs stable during stalls; pixel sequence identical to the unstalled run.
- Two vertices accepted, then obj_done_in=1 → no pixels; vcnt cleared; obj_done_out=1 one cycle later.
- Reset asserted mid-DRAW → next cycle pix_valid_out=0 and ready_out=0; the following triangle draws correctly.
